logic_gate_sweep: RTL and testbench
===================================

LOGIC_GATE_SWEEP -- requirements
Module: logic_gate_sweep

Interface
REQ-001 SHALL have parameter N_IN, default 2: number of single-bit gate inputs, legal range 2..8.
REQ-002 SHALL have parameter CNT_W, default N_IN+1: sweep counter width, wide enough to hold 2^N_IN.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port op, input, 3 bits: gate select (000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 BUF of bit 0, 111 NOT of bit 0).
REQ-006 SHALL have port in_vec, input, N_IN bits: direct-mode gate operands.
REQ-007 SHALL have port in_valid, input, 1 bit: the in_vec/op beat is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts a direct-mode beat this cycle.
REQ-009 SHALL have port start, input, 1 bit: single-cycle request to run a truth-table sweep.
REQ-010 SHALL have port busy, output, 1 bit: a sweep is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-012 SHALL have port out_vec, output, N_IN bits: operand vector that produced out_x.
REQ-013 SHALL have port out_x, output, 1 bit: gate result.
REQ-014 SHALL have port out_valid, output, 1 bit: out_vec/out_x are valid.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream accepts the output beat.

Function
REQ-016 SHALL implement a one-stage output register; a beat loads when (!out_valid || out_ready), called "slot free".
REQ-017 SHALL hold out_vec, out_x and out_valid stable while out_valid=1 and out_ready=0.
REQ-018 SHALL compute out_x as the N_IN-input reduction of the loaded vector under the op in effect; BUF/NOT use bit 0 only.
REQ-019 SHALL have FSM states IDLE, SWEEP, DONE.
REQ-020 SHALL, in IDLE, drive in_ready = slot free; in_valid && in_ready loads {in_vec, op result}; latency 1 cycle from acceptance to out_valid.
REQ-021 SHALL, in IDLE with start=1, latch op into sweep_op, clear the counter to 0 and enter SWEEP; start takes priority over in_valid in that cycle and the direct beat is not accepted (in_ready=0).
REQ-022 SHALL, in SWEEP, drive in_ready=0, busy=1, and ignore in_valid, op and start.
REQ-023 SHALL, in SWEEP, load out_vec = counter[N_IN-1:0] with the sweep_op result whenever the slot is free, then increment the counter.
REQ-024 SHALL stall the counter while the slot is not free (no vector skipped or repeated).
REQ-025 SHALL, when the vector 2^N_IN-1 loads, transition to DONE on the next edge; the counter never wraps to 0 within a sweep.
REQ-026 SHALL, in DONE, assert done=1 for exactly one cycle, keep busy=1, load nothing, and return to IDLE; the final beat may still be pending at the output.
REQ-027 SHALL emit vectors in ascending order 0..2^N_IN-1, exactly 2^N_IN beats per sweep.
REQ-028 SHALL ignore start asserted in SWEEP or DONE (not queued).

Reset
REQ-029 SHALL, on rst=1 at a clock edge, set the FSM to IDLE, counter=0, out_valid=0, out_vec=0, out_x=0, done=0, busy=0, sweep_op=000; in_ready then evaluates to 1.
REQ-030 SHALL abort a sweep in progress on reset with no done pulse; a pending output beat is discarded.
REQ-031 SHALL give rst priority over start, in_valid and out_ready in the same cycle.

Verification
REQ-032 SHALL pass: N_IN=2, op=001, out_ready=1, in_vec 00,01,10,11 with in_valid=1 on consecutive cycles -> out_x 0,1,1,1, each one cycle after acceptance.
REQ-033 SHALL pass: N_IN=3, op=010, start pulse, out_ready=1 -> 8 beats out_vec 000..111 with out_x 0,1,1,0,1,0,0,1; done pulses once, one cycle after the last load; busy high throughout.
REQ-034 SHALL pass: sweep with op=011 and out_ready toggling 1,0,0,1,... -> the same 4 ordered beats (x=1,1,1,0), each held stable while stalled, none lost or duplicated.
REQ-035 SHALL pass: start and in_valid asserted together in IDLE -> sweep begins, direct beat not accepted (in_ready=0 that cycle).
REQ-036 SHALL pass: rst asserted mid-sweep after vector 01 is loaded -> next cycle out_valid=0, busy=0, done never pulses, in_ready=1.
REQ-037 SHALL pass: op=111, in_vec=10 -> out_x=1; op=110, in_vec=10 -> out_x=0.

Source files
------------

// File: rtl/logic_gate_sweep.sv
// logic_gate_sweep: a configurable N_IN-input logic gate with a one-deep output register.
// Direct mode evaluates one in_vec/op beat per accepted handshake. Sweep mode walks the
// whole truth table 0..2^N_IN-1 under a latched op and back-pressures on out_ready.
module logic_gate_sweep #(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned CNT_W = N_IN + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      op,
  input  logic [N_IN-1:0] in_vec,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [N_IN-1:0] out_vec,
  output logic            out_x,
  output logic            out_valid,
  input  logic            out_ready
);

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDone
  } state_e;

  // Last truth-table row; CNT_W > N_IN, so the counter never has to wrap to reach it.
  localparam logic [CNT_W-1:0] LastVec = {{(CNT_W - N_IN){1'b0}}, {N_IN{1'b1}}};
  localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W - 1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntZero = {CNT_W{1'b0}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        sweep_op_q, sweep_op_d;
  logic [N_IN-1:0]   out_vec_q, out_vec_d;
  logic              out_x_q, out_x_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              slot_free;
  logic [N_IN-1:0]   sweep_vec;

  // Reduce the operand vector under the selected gate; BUF/NOT look at bit 0 only.
  function automatic logic gate_eval(input logic [2:0] sel, input logic [N_IN-1:0] v);
    logic r;
    case (sel)
      3'b000:  r = &v;
      3'b001:  r = |v;
      3'b010:  r = ^v;
      3'b011:  r = ~&v;
      3'b100:  r = ~|v;
      3'b101:  r = ~^v;
      3'b110:  r = v[0];
      default: r = ~v[0];
    endcase
    return r;
  endfunction

  // Output slot can take a new beat when empty or being drained this cycle.
  always_comb begin
    slot_free = !out_valid_q || out_ready;
    sweep_vec = cnt_q[N_IN-1:0];
    in_ready  = (state_q == StIdle) && !start && slot_free;
  end

  // Next-state: FSM, sweep counter and output register load.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sweep_op_d  = sweep_op_q;
    out_vec_d   = out_vec_q;
    out_x_d     = out_x_q;
    // A free slot with nothing new to load means the held beat was consumed (or absent).
    out_valid_d = slot_free ? 1'b0 : out_valid_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          // start wins over a coincident direct beat; in_ready is already low.
          sweep_op_d = op;
          cnt_d      = CntZero;
          state_d    = StSweep;
        end else if (in_valid && slot_free) begin
          out_vec_d   = in_vec;
          out_x_d     = gate_eval(op, in_vec);
          out_valid_d = 1'b1;
        end
      end
      StSweep: begin
        // Counter only advances on a load, so stalls neither skip nor repeat rows.
        if (slot_free) begin
          out_vec_d   = sweep_vec;
          out_x_d     = gate_eval(sweep_op_q, sweep_vec);
          out_valid_d = 1'b1;
          cnt_d       = cnt_q + CntOne;
          if (cnt_q == LastVec) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // Final beat may still be waiting at the output; nothing new is loaded here.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  // State and registered outputs; synchronous reset dominates every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= CntZero;
      sweep_op_q  <= 3'b000;
      out_vec_q   <= {N_IN{1'b0}};
      out_x_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sweep_op_q  <= sweep_op_d;
      out_vec_q   <= out_vec_d;
      out_x_q     <= out_x_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_vec   = out_vec_q;
  assign out_x     = out_x_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_logic_gate_sweep.sv
// Scoreboard bench for logic_gate_sweep: a 2-input and a 3-input instance. Stimulus pushes
// hand-computed {vec, x} beats into per-instance queues; monitors pop them on handshakes.
module tb_logic_gate_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] op;

  logic [1:0] in_vec2, out_vec2;
  logic       in_valid2, in_ready2, start2, busy2, done2, out_x2, out_valid2, out_ready2;
  logic [2:0] in_vec3, out_vec3;
  logic       in_valid3, in_ready3, start3, busy3, done3, out_x3, out_valid3, out_ready3;

  logic [3:0] q2[$];
  logic [3:0] q3[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt2 = 0;
  int done_cnt3 = 0;

  logic_gate_sweep #(.N_IN(2)) dut2 (
    .clk(clk), .rst(rst), .op(op), .in_vec(in_vec2), .in_valid(in_valid2),
    .in_ready(in_ready2), .start(start2), .busy(busy2), .done(done2), .out_vec(out_vec2),
    .out_x(out_x2), .out_valid(out_valid2), .out_ready(out_ready2)
  );

  logic_gate_sweep #(.N_IN(3)) dut3 (
    .clk(clk), .rst(rst), .op(op), .in_vec(in_vec3), .in_valid(in_valid3),
    .in_ready(in_ready3), .start(start3), .busy(busy3), .done(done3), .out_vec(out_vec3),
    .out_x(out_x3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the 2-input instance: scoreboard pop on handshake, hold check on stall.
  initial begin : mon2
    logic       hold_v;
    logic [2:0] held;
    logic [3:0] e;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (done2) done_cnt2++;
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v)
          check("hold2", 32'({out_valid2, out_vec2, out_x2}), 32'({1'b1, held}));
        if (out_valid2 && out_ready2) begin
          n_checks++;
          if (q2.size() == 0) begin
            n_fail++;
            $display("FAIL extra2: got beat %0h expected none", {out_vec2, out_x2});
          end else begin
            e = q2.pop_front();
            n_checks--;
            check("beat2", 32'({out_vec2, out_x2}), 32'(e[2:0]));
          end
          hold_v = 1'b0;
        end else if (out_valid2) begin
          hold_v = 1'b1;
          held   = {out_vec2, out_x2};
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  // Monitor for the 3-input instance.
  initial begin : mon3
    logic       hold_v;
    logic [3:0] held;
    logic [3:0] e;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (done3) done_cnt3++;
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v)
          check("hold3", 32'({out_valid3, out_vec3, out_x3}), 32'({1'b1, held}));
        if (out_valid3 && out_ready3) begin
          n_checks++;
          if (q3.size() == 0) begin
            n_fail++;
            $display("FAIL extra3: got beat %0h expected none", {out_vec3, out_x3});
          end else begin
            e = q3.pop_front();
            n_checks--;
            check("beat3", 32'({out_vec3, out_x3}), 32'(e));
          end
          hold_v = 1'b0;
        end else if (out_valid3) begin
          hold_v = 1'b1;
          held   = {out_vec3, out_x3};
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  // One direct-mode beat on the 2-input instance, consecutive calls give back-to-back beats.
  task automatic direct_beat(input logic [2:0] o, input logic [1:0] v, input logic x);
    op        = o;
    in_vec2   = v;
    in_valid2 = 1'b1;
    q2.push_back({1'b0, v, x});
    @(negedge clk);
    check("dir_rdy", 32'(in_ready2), 32'd1);
    @(posedge clk);
    #1;
    check("dir_lat", 32'({out_valid2, out_vec2}), 32'({1'b1, v}));
  endtask

  // Truth-table sweep; xs bit v is the hand-computed result for row v, pat drives out_ready.
  task automatic run_sweep(input logic sel, input logic [2:0] sop, input logic [7:0] xs,
                           input logic [3:0] pat, input logic with_valid);
    int  rows;
    bit  seen;
    bit  post;
    logic [2:0] last;
    rows = sel ? 8 : 4;
    last = sel ? 3'b111 : 3'b011;
    seen = 1'b0;
    post = 1'b0;
    done_cnt2 = 0;
    done_cnt3 = 0;
    @(posedge clk);
    #1;
    op = sop;
    for (int v = 0; v < rows; v++) begin
      if (sel) q3.push_back({3'(v), xs[v]});
      else     q2.push_back({1'b0, 2'(v), xs[v]});
    end
    if (sel) start3 = 1'b1;
    else     start2 = 1'b1;
    if (with_valid) begin
      in_valid2 = 1'b1;
      in_vec2   = 2'b01;
    end
    @(negedge clk);
    check("start_rdy", 32'(sel ? in_ready3 : in_ready2), 32'd0);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk);
      #1;
      op = ~sop;
      start2 = (!sel && cyc == 2);
      start3 = (sel && cyc == 2);
      if (sel) out_ready3 = pat[cyc % 4];
      else     out_ready2 = pat[cyc % 4];
      @(negedge clk);
      if (!seen) begin
        check("busy", 32'(sel ? busy3 : busy2), 32'd1);
        check("sw_rdy", 32'(sel ? in_ready3 : in_ready2), 32'd0);
        if (sel ? done3 : done2) begin
          seen = 1'b1;
          in_valid2 = 1'b0;
          if (sel) check("done_last", 32'({out_valid3, out_vec3}), 32'({1'b1, last}));
          else     check("done_last", 32'({out_valid2, out_vec2}), 32'({1'b1, last[1:0]}));
        end
      end else if (!post) begin
        check("busy_end", 32'(sel ? busy3 : busy2), 32'd0);
        post = 1'b1;
      end
      if (seen && post && !(sel ? out_valid3 : out_valid2)) break;
    end
    if (!seen) check("done_seen", 32'd0, 32'd1);
    in_valid2  = 1'b0;
    out_ready2 = 1'b1;
    out_ready3 = 1'b1;
    @(posedge clk);
    #1;
    check("done_cnt", 32'(sel ? done_cnt3 : done_cnt2), 32'd1);
    check("q_empty", 32'(sel ? q3.size() : q2.size()), 32'd0);
  endtask

  // Directed {op, vec, x} vectors, results worked out by hand.
  logic [5:0] misc_tbl[12] = '{
    {3'b111, 2'b10, 1'b1}, {3'b110, 2'b10, 1'b0}, {3'b000, 2'b11, 1'b1},
    {3'b000, 2'b10, 1'b0}, {3'b011, 2'b11, 1'b0}, {3'b100, 2'b00, 1'b1},
    {3'b100, 2'b01, 1'b0}, {3'b010, 2'b11, 1'b0}, {3'b101, 2'b01, 1'b0},
    {3'b101, 2'b11, 1'b1}, {3'b111, 2'b01, 1'b0}, {3'b110, 2'b01, 1'b1}
  };

  initial begin : main
    logic [3:0] or_x;
    bit         found;
    rst = 1'b1;
    op = 3'b000;
    in_vec2 = '0; in_valid2 = 1'b0; start2 = 1'b0; out_ready2 = 1'b1;
    in_vec3 = '0; in_valid3 = 1'b0; start3 = 1'b0; out_ready3 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid2), 32'd0);
    check("rst_vec",   32'(out_vec2),   32'd0);
    check("rst_x",     32'(out_x2),     32'd0);
    check("rst_done",  32'(done2),      32'd0);
    check("rst_busy",  32'(busy2),      32'd0);
    check("rst_rdy",   32'(in_ready2),  32'd1);
    check("rst_valid3", 32'(out_valid3), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // OR over 00,01,10,11 on consecutive cycles -> 0,1,1,1
    or_x = 4'b1110;
    for (int i = 0; i < 4; i++) direct_beat(3'b001, 2'(i), or_x[i]);
    foreach (misc_tbl[i]) direct_beat(misc_tbl[i][5:3], misc_tbl[i][2:1], misc_tbl[i][0]);
    in_valid2 = 1'b0;
    repeat (3) @(posedge clk);

    // XOR sweep on 3 inputs, always ready
    run_sweep(1'b1, 3'b010, 8'b1001_0110, 4'b1111, 1'b0);
    // NAND sweep with out_ready 1,0,0,1,...
    run_sweep(1'b0, 3'b011, 8'b0000_0111, 4'b1001, 1'b0);
    // start together with in_valid: AND sweep, direct beat dropped
    run_sweep(1'b0, 3'b000, 8'b0000_1000, 4'b1111, 1'b1);
    repeat (2) @(posedge clk);

    // Reset mid-sweep once row 01 has loaded
    #1;
    op = 3'b001;
    q2.push_back({1'b0, 2'b00, 1'b0});
    q2.push_back({1'b0, 2'b01, 1'b1});
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (out_valid2 && out_vec2 == 2'b01) found = 1'b1;
    end
    check("rst_wait", 32'(found), 32'd1);
    #1;
    rst = 1'b1;
    done_cnt2 = 0;
    @(posedge clk);
    #1;
    check("mid_valid", 32'(out_valid2), 32'd0);
    check("mid_busy",  32'(busy2),      32'd0);
    check("mid_rdy",   32'(in_ready2),  32'd1);
    check("mid_done",  32'(done2),      32'd0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid_nodone", 32'(done_cnt2), 32'd0);
    check("mid_idle",   32'(out_valid2), 32'd0);
    check("q2_empty",   32'(q2.size()), 32'd0);
    check("q3_empty",   32'(q3.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
